axicb_slv_wr_gate: RTL and testbench
====================================

AXICB_SLV_WR_GATE -- requirements
Module: axicb_slv_wr_gate

Interface
REQ-001 SHALL have parameter AWCH_W, default 8, meaning the concatenated AW channel width.
REQ-002 SHALL have parameter WCH_W, default 8, meaning the concatenated W channel width.
REQ-003 SHALL have parameter BCH_W, default 8, meaning the concatenated B channel width.
REQ-004 SHALL have parameter MAX_OSTD, default 4 (range 1..255), meaning the max outstanding writes.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the B-wait timeout in cycles.
REQ-006 SHALL have port aclk, input, 1, the single clock.
REQ-007 SHALL have port aresetn, input, 1, the reset, asynchronous and active-low.
REQ-008 SHALL have ports i_awvalid in 1, i_awready out 1, i_awch in AWCH_W; this is the upstream switch AW.
REQ-009 SHALL have ports i_wvalid in 1, i_wready out 1, i_wlast in 1, i_wch in WCH_W; this is the upstream W.
REQ-010 SHALL have ports i_bvalid out 1, i_bready in 1, i_bch out BCH_W; this is the upstream B.
REQ-011 SHALL have ports o_awvalid/o_awready/o_awch, o_wvalid/o_wready/o_wlast/o_wch and o_bvalid/o_bready/o_bch, mirroring the above toward the slave.
REQ-012 SHALL have port err_unexp_b, output, 1, a sticky flag for a B received with zero outstanding.
REQ-013 SHALL have port err_timeout, output, 1, a sticky flag for a B-wait timeout.

Function
REQ-014 SHALL keep ostd (0..MAX_OSTD): +1 on an AW handshake, -1 on a B handshake, net 0 when both occur in the same cycle.
REQ-015 SHALL keep wpend (0..MAX_OSTD): +1 on an AW handshake, -1 on a W handshake with wlast=1, net 0 when both occur in the same cycle.
REQ-016 SHALL drive o_awvalid = i_awvalid & (ostd<MAX_OSTD) and i_awready = o_awready & (ostd<MAX_OSTD), combinationally; o_awch = i_awch.
REQ-017 SHALL drive o_wvalid = i_wvalid & (wpend>0) and i_wready = o_wready & (wpend>0); a W beat never passes in the same cycle as its own AW.
REQ-018 SHALL pass o_wch and o_wlast through unchanged.
REQ-019 SHALL drive i_bvalid = o_bvalid & (ostd>0) and o_bready = i_bready | (ostd==0); a B arriving with ostd==0 is drained and sets err_unexp_b.
REQ-020 SHALL pass i_bch = o_bch.
REQ-021 SHALL never let ostd or wpend wrap; the gating in REQ-016/017/019 makes overflow and underflow unreachable.
REQ-022 SHALL run a timeout FSM with states IDLE, WAIT and EXPIRED.
REQ-023 SHALL transition the FSM as follows: IDLE->WAIT when ostd becomes >0; WAIT->IDLE on ostd==0.
REQ-024 SHALL clear the timer on any B handshake while in WAIT.
REQ-025 SHALL move WAIT->EXPIRED when the timer reaches TIMEOUT_CYC-1 without a B handshake; EXPIRED sets err_timeout and returns to IDLE when ostd==0.
REQ-026 SHALL keep err flags set until reset.

Reset
REQ-027 SHALL, on aresetn low, asynchronously clear ostd, wpend, the timer, both err flags and the FSM (FSM goes to IDLE).
REQ-028 SHALL allow the combinational outputs to follow the reset state: i_awready=o_awready, i_wready=0, o_wvalid=0, i_bvalid=0.
REQ-029 SHALL treat reset mid-burst as an abandonment of in-flight transactions; no recovery is attempted.

Configuration
REQ-030 SHALL, with macro AXICB_WR_TIMEOUT_EN defined, implement REQ-022..025.
REQ-031 SHALL, without AXICB_WR_TIMEOUT_EN, remove the FSM and timer and tie err_timeout to 0; all other behaviour is unchanged.

Structure
REQ-032 SHALL place the timeout FSM state enum and a counter-width helper ($clog2(MAX_OSTD+1)) in shared package axicb_pkg.
REQ-033 SHALL instantiate sub-module axicb_updn_cnt (an inc/dec counter with same-cycle net update) twice, once for ostd and once for wpend.

Verification
REQ-034 SHALL cover: MAX_OSTD=2, three back-to-back AWs with B held off -> third AW sees i_awready=0 until the first B handshake.
REQ-035 SHALL cover: a W beat presented before any AW -> i_wready=0 and o_wvalid=0; after the AW handshake, the W passes the next cycle.
REQ-036 SHALL cover: AW handshake and B handshake in the same cycle with ostd=1 -> ostd stays 1.
REQ-037 SHALL cover: a 4-beat W burst with wlast on beat 4 -> wpend decrements only after beat 4.
REQ-038 SHALL cover: o_bvalid=1 with ostd=0 -> o_bready=1, i_bvalid=0 and err_unexp_b=1 the next cycle, held.
REQ-039 SHALL cover: with AXICB_WR_TIMEOUT_EN and TIMEOUT_CYC=16, one AW and no B -> err_timeout=1 after 16 cycles; without the macro, err_timeout stays 0.

Source files
------------

// File: rtl/axicb_pkg.sv
// Shared definitions for the AXI crossbar slave-side write gate:
// timeout FSM state encoding and the outstanding-counter width helper.
package axicb_pkg;

  typedef enum logic [1:0] {
    TO_IDLE    = 2'd0,
    TO_WAIT    = 2'd1,
    TO_EXPIRED = 2'd2
  } to_state_e;

  // Bits needed to hold a count in 0..max_ostd inclusive.
  function automatic int ostd_cnt_w(input int max_ostd);
    return $clog2(max_ostd + 1);
  endfunction

endpackage

// File: rtl/axicb_updn_cnt.sv
// Up/down counter: inc and dec asserted together leave the count unchanged.
// Callers gate inc/dec so the count never wraps.
module axicb_updn_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Net update: a simultaneous inc and dec cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/axicb_slv_wr_gate.sv
// Slave-side write gate for the AXI crossbar. Limits outstanding writes to
// MAX_OSTD, holds W beats until their AW has been accepted, drains stray B
// responses, and flags protocol errors.
// Optional B-wait watchdog enabled by defining AXICB_WR_TIMEOUT_EN.
module axicb_slv_wr_gate
  import axicb_pkg::*;
#(
  parameter int AWCH_W      = 8,
  parameter int WCH_W       = 8,
  parameter int BCH_W       = 8,
  parameter int MAX_OSTD    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  // upstream (switch side)
  input  logic              i_awvalid,
  output logic              i_awready,
  input  logic [AWCH_W-1:0] i_awch,
  input  logic              i_wvalid,
  output logic              i_wready,
  input  logic              i_wlast,
  input  logic [WCH_W-1:0]  i_wch,
  output logic              i_bvalid,
  input  logic              i_bready,
  output logic [BCH_W-1:0]  i_bch,
  // downstream (slave side)
  output logic              o_awvalid,
  input  logic              o_awready,
  output logic [AWCH_W-1:0] o_awch,
  output logic              o_wvalid,
  input  logic              o_wready,
  output logic              o_wlast,
  output logic [WCH_W-1:0]  o_wch,
  input  logic              o_bvalid,
  output logic              o_bready,
  input  logic [BCH_W-1:0]  o_bch,
  // sticky error flags
  output logic              err_unexp_b,
  output logic              err_timeout
);

  localparam int CNT_W = ostd_cnt_w(MAX_OSTD);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OSTD);

  logic [CNT_W-1:0] ostd;
  logic [CNT_W-1:0] wpend;
  logic             ostd_lt_max;
  logic             ostd_nz;
  logic             wpend_nz;
  logic             aw_hs;
  logic             w_last_hs;
  logic             b_hs;
  logic             unexp_b;
  logic             err_unexp_b_q;
  logic             err_unexp_b_d;

  // Handshake gating and payload pass-through; all combinational.
  always_comb begin
    ostd_lt_max = (ostd < MAX_CNT);
    ostd_nz     = (ostd != '0);
    wpend_nz    = (wpend != '0);

    o_awvalid   = i_awvalid & ostd_lt_max;
    i_awready   = o_awready & ostd_lt_max;
    o_awch      = i_awch;

    // wpend only rises after the AW edge, so a W never rides with its own AW.
    o_wvalid    = i_wvalid & wpend_nz;
    i_wready    = o_wready & wpend_nz;
    o_wlast     = i_wlast;
    o_wch       = i_wch;

    // With nothing outstanding, a B is swallowed here instead of forwarded.
    i_bvalid    = o_bvalid & ostd_nz;
    o_bready    = i_bready | ~ostd_nz;
    i_bch       = o_bch;

    aw_hs       = i_awvalid & o_awready & ostd_lt_max;
    w_last_hs   = i_wvalid & o_wready & wpend_nz & i_wlast;
    b_hs        = o_bvalid & i_bready & ostd_nz;
    unexp_b     = o_bvalid & ~ostd_nz;

    err_unexp_b_d = err_unexp_b_q | unexp_b;
  end

  axicb_updn_cnt #(
    .W (CNT_W)
  ) u_ostd_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (aw_hs),
    .dec   (b_hs),
    .cnt   (ostd)
  );

  axicb_updn_cnt #(
    .W (CNT_W)
  ) u_wpend_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (aw_hs),
    .dec   (w_last_hs),
    .cnt   (wpend)
  );

  // Sticky unexpected-B flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_unexp_b_q <= 1'b0;
    end else begin
      err_unexp_b_q <= err_unexp_b_d;
    end
  end

  assign err_unexp_b = err_unexp_b_q;

`ifdef AXICB_WR_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  to_state_e        state_q;
  to_state_e        state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  logic             err_timeout_q;
  logic             err_timeout_d;

  // Watchdog state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= TO_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Watchdog next state: arm while writes are outstanding, expire when no B
  // arrives within TIMEOUT_CYC cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TO_IDLE: begin
        if (ostd_nz) state_d = TO_WAIT;
      end
      TO_WAIT: begin
        if (!ostd_nz) begin
          state_d = TO_IDLE;
        end else if (!b_hs && (tmr_q == TMR_LAST)) begin
          state_d = TO_EXPIRED;
        end
      end
      TO_EXPIRED: begin
        if (!ostd_nz) state_d = TO_IDLE;
      end
      default: state_d = TO_IDLE;
    endcase
  end

  // Watchdog outputs: timer restarts on every B handshake, error on expiry.
  always_comb begin
    tmr_d         = '0;
    err_timeout_d = err_timeout_q;
    if (state_q == TO_WAIT) begin
      if (b_hs || !ostd_nz) begin
        tmr_d = '0;
      end else if (tmr_q == TMR_LAST) begin
        tmr_d         = '0;
        err_timeout_d = 1'b1;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end
  end

  // Timer and sticky timeout flag registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tmr_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tmr_q         <= tmr_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  // Watchdog absent: flag tied low; TIMEOUT_CYC is still referenced so both
  // builds share one parameter list without an unused-parameter warning.
  assign err_timeout = 1'b0 & (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_axicb_slv_wr_gate.sv
// Bench for axicb_slv_wr_gate: directed corner cases plus randomized
// master/slave traffic, checked by a scoreboard monitor and a count model.
module tb_axicb_slv_wr_gate;

  localparam int AW_W = 8;
  localparam int W_W  = 8;
  localparam int B_W  = 8;
  localparam int MAXO = 2;
  localparam int TO   = 16;
  localparam int N    = 150;
`ifdef AXICB_WR_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  logic            aclk;
  logic            aresetn;
  logic            i_awvalid, i_awready;
  logic [AW_W-1:0] i_awch;
  logic            i_wvalid, i_wready, i_wlast;
  logic [W_W-1:0]  i_wch;
  logic            i_bvalid, i_bready;
  logic [B_W-1:0]  i_bch;
  logic            o_awvalid, o_awready;
  logic [AW_W-1:0] o_awch;
  logic            o_wvalid, o_wready, o_wlast;
  logic [W_W-1:0]  o_wch;
  logic            o_bvalid, o_bready;
  logic [B_W-1:0]  o_bch;
  logic            err_unexp_b, err_timeout;

  axicb_slv_wr_gate #(
    .AWCH_W(AW_W), .WCH_W(W_W), .BCH_W(B_W), .MAX_OSTD(MAXO), .TIMEOUT_CYC(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
    .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
    .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
    .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
    .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
    .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
    .err_unexp_b(err_unexp_b), .err_timeout(err_timeout)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  logic [AW_W-1:0] aw_q[$];
  logic [W_W:0]    w_q[$];
  logic [B_W-1:0]  b_q[$];

  // reference model: counts derived from observed upstream handshakes
  int m_ostd  = 0;
  int m_wpend = 0;
  bit m_unexp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=handshake required=none-expected at %0t", name, $time);
  endtask

  task automatic to_neg();
    @(negedge aclk);
  endtask

  task automatic to_drv();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard monitor and gating model, sampled on the falling edge.
  always @(negedge aclk) begin
    logic up_aw, up_w, up_b, dn_b;
    if (!aresetn) begin
      m_ostd  = 0;
      m_wpend = 0;
      m_unexp = 1'b0;
    end else begin
      chk("gate_o_awvalid", o_awvalid, i_awvalid && (m_ostd < MAXO));
      chk("gate_i_awready", i_awready, o_awready && (m_ostd < MAXO));
      chk("gate_o_wvalid",  o_wvalid,  i_wvalid && (m_wpend > 0));
      chk("gate_i_wready",  i_wready,  o_wready && (m_wpend > 0));
      chk("gate_i_bvalid",  i_bvalid,  o_bvalid && (m_ostd > 0));
      chk("gate_o_bready",  o_bready,  i_bready || (m_ostd == 0));
      chk("err_unexp_model", err_unexp_b, m_unexp);

      if (o_awvalid && o_awready) begin
        if (aw_q.size() == 0) miss("aw_extra");
        else chk("aw_payload", o_awch, aw_q.pop_front());
      end
      if (o_wvalid && o_wready) begin
        if (w_q.size() == 0) miss("w_extra");
        else chk("w_payload", {o_wlast, o_wch}, w_q.pop_front());
      end
      if (i_bvalid && i_bready) begin
        if (b_q.size() == 0) miss("b_extra");
        else chk("b_payload", i_bch, b_q.pop_front());
      end

      up_aw = i_awvalid && i_awready;
      up_w  = i_wvalid && i_wready && i_wlast;
      up_b  = i_bvalid && i_bready;
      dn_b  = o_bvalid && o_bready;
      if (dn_b && (m_ostd == 0)) m_unexp = 1'b1;
      m_ostd  = m_ostd + int'(up_aw) - int'(up_b);
      m_wpend = m_wpend + int'(up_aw) - int'(up_w);
    end
  end

  // ch: 0=AW upstream, 1=W upstream, 2=B upstream
  task automatic wait_hs(input int ch, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      to_neg();
      if ((ch == 0 && i_awvalid && i_awready) ||
          (ch == 1 && i_wvalid && i_wready) ||
          (ch == 2 && i_bvalid && i_bready)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1'b1);
    to_drv();
  endtask

  task automatic do_aw(input logic [AW_W-1:0] d);
    i_awvalid = 1'b1; i_awch = d; o_awready = 1'b1; aw_q.push_back(d);
    wait_hs(0, "aw_hs_reached");
    i_awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [W_W-1:0] d, input logic last);
    i_wvalid = 1'b1; i_wch = d; i_wlast = last; o_wready = 1'b1; w_q.push_back({last, d});
    wait_hs(1, "w_hs_reached");
    i_wvalid = 1'b0;
  endtask

  task automatic do_b(input logic [B_W-1:0] d);
    o_bvalid = 1'b1; o_bch = d; i_bready = 1'b1; b_q.push_back(d);
    wait_hs(2, "b_hs_reached");
    o_bvalid = 1'b0;
  endtask

  task automatic do_reset();
    to_drv();
    aresetn = 1'b0;
    #2;
    chk("rst_err_unexp", err_unexp_b, 1'b0);
    chk("rst_err_timeout", err_timeout, 1'b0);
    to_drv();
    to_drv();
    aresetn = 1'b1;
    to_drv();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int len[N];
    int aw_iss, w_bursts, w_beat, slv_aw, slv_wl, slv_b, cyc;
    bit aw_f, w_f, awo_f, wl_f, bo_f;

    aresetn = 1'b0;
    i_awvalid = 1'b0; i_awch = '0; i_wvalid = 1'b1; i_wlast = 1'b0; i_wch = '0;
    i_bready = 1'b0; o_awready = 1'b1; o_wready = 1'b1; o_bvalid = 1'b1; o_bch = '0;

    // reset state: combinational outputs follow the cleared counters
    #3;
    chk("rst_i_awready", i_awready, 1'b1);
    chk("rst_i_wready", i_wready, 1'b0);
    chk("rst_o_wvalid", o_wvalid, 1'b0);
    chk("rst_i_bvalid", i_bvalid, 1'b0);
    chk("rst_err_unexp0", err_unexp_b, 1'b0);
    chk("rst_err_timeout0", err_timeout, 1'b0);
    i_wvalid = 1'b0; o_bvalid = 1'b0;
    to_drv();
    aresetn = 1'b1;
    to_drv();

    // W ahead of its AW is held, then passes the cycle after the AW
    i_wvalid = 1'b1; i_wch = 8'h21; i_wlast = 1'b1; o_wready = 1'b1; w_q.push_back({1'b1, 8'h21});
    to_neg();
    chk("early_w_i_wready", i_wready, 1'b0);
    chk("early_w_o_wvalid", o_wvalid, 1'b0);
    to_drv();
    i_awvalid = 1'b1; i_awch = 8'h20; o_awready = 1'b1; aw_q.push_back(8'h20);
    to_neg();
    chk("w_not_with_aw", o_wvalid, 1'b0);
    to_drv();
    i_awvalid = 1'b0;
    to_neg();
    chk("w_after_aw_valid", o_wvalid, 1'b1);
    chk("w_after_aw_ready", i_wready, 1'b1);
    to_drv();
    i_wvalid = 1'b0;
    do_b(8'h22);

    // MAX_OSTD=2: third AW blocked until the first B handshake
    do_aw(8'h31);
    do_aw(8'h32);
    i_awvalid = 1'b1; i_awch = 8'h33; aw_q.push_back(8'h33);
    do_w(8'h34, 1'b1);
    do_w(8'h35, 1'b1);
    to_neg();
    chk("aw3_blocked_ready", i_awready, 1'b0);
    chk("aw3_blocked_valid", o_awvalid, 1'b0);
    to_drv();
    do_b(8'h36);
    to_neg();
    chk("aw3_unblocked", i_awready, 1'b1);
    to_drv();
    i_awvalid = 1'b0;
    do_w(8'h37, 1'b1);
    do_b(8'h38);
    do_b(8'h39);

    // AW and B in the same cycle with one outstanding: count stays 1
    do_aw(8'h41);
    do_w(8'h42, 1'b1);
    i_awvalid = 1'b1; i_awch = 8'h43; aw_q.push_back(8'h43);
    o_bvalid = 1'b1; o_bch = 8'h44; i_bready = 1'b1; b_q.push_back(8'h44);
    to_neg();
    chk("same_cyc_aw_fire", i_awready, 1'b1);
    chk("same_cyc_b_fire", i_bvalid, 1'b1);
    to_drv();
    i_awvalid = 1'b0; i_bready = 1'b0; o_bvalid = 1'b1; o_bch = 8'h45;
    to_neg();
    chk("same_cyc_ostd_nz", i_bvalid, 1'b1);
    chk("same_cyc_ostd_lt2", i_awready, 1'b1);
    to_drv();
    do_w(8'h46, 1'b1);
    do_b(8'h47);

    // 4-beat burst: wpend drops only after the wlast beat
    do_aw(8'h51);
    i_wvalid = 1'b1; o_wready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_wch = 8'(8'h52 + k); i_wlast = (k == 3); w_q.push_back({(k == 3), 8'(8'h52 + k)});
      to_neg();
      chk("burst_beat_ready", i_wready, 1'b1);
      to_drv();
    end
    i_wch = 8'h5f; i_wlast = 1'b1;
    to_neg();
    chk("burst_closed_ready", i_wready, 1'b0);
    chk("burst_closed_valid", o_wvalid, 1'b0);
    to_drv();
    i_wvalid = 1'b0;
    do_b(8'h56);

    // B with nothing outstanding is drained and flagged, sticky
    o_bvalid = 1'b1; o_bch = 8'h61; i_bready = 1'b0;
    to_neg();
    chk("unexp_o_bready", o_bready, 1'b1);
    chk("unexp_i_bvalid", i_bvalid, 1'b0);
    chk("unexp_flag_pre", err_unexp_b, 1'b0);
    to_drv();
    o_bvalid = 1'b0;
    to_neg();
    chk("unexp_flag_set", err_unexp_b, 1'b1);
    for (int k = 0; k < 3; k++) begin
      to_drv();
      to_neg();
      chk("unexp_flag_held", err_unexp_b, 1'b1);
    end
    to_drv();
    do_reset();

    // randomized traffic: master and slave with random valids/readies
    for (int i = 0; i < N; i++) len[i] = int'($urandom_range(1, 4));
    aw_iss = 0; w_bursts = 0; w_beat = 0; slv_aw = 0; slv_wl = 0; slv_b = 0; cyc = 0;
    while (slv_b < N && cyc < 20000) begin
      to_neg();
      aw_f  = i_awvalid && i_awready;
      w_f   = i_wvalid && i_wready;
      awo_f = o_awvalid && o_awready;
      wl_f  = o_wvalid && o_wready && o_wlast;
      bo_f  = o_bvalid && o_bready;
      to_drv();
      cyc++;
      if (aw_f) i_awvalid = 1'b0;
      if (!i_awvalid && aw_iss < N && $urandom_range(0, 3) != 0) begin
        i_awvalid = 1'b1; i_awch = 8'($urandom); aw_q.push_back(i_awch); aw_iss++;
      end
      if (w_f) begin
        i_wvalid = 1'b0;
        if (i_wlast) begin w_bursts++; w_beat = 0; end
        else w_beat++;
      end
      if (!i_wvalid && w_bursts < N && $urandom_range(0, 3) != 0) begin
        i_wvalid = 1'b1; i_wch = 8'($urandom); i_wlast = (w_beat == len[w_bursts] - 1);
        w_q.push_back({i_wlast, i_wch});
      end
      if (awo_f) slv_aw++;
      if (wl_f) slv_wl++;
      if (bo_f) begin o_bvalid = 1'b0; slv_b++; end
      if (!o_bvalid && slv_b < ((slv_aw < slv_wl) ? slv_aw : slv_wl) && $urandom_range(0, 2) != 0) begin
        o_bvalid = 1'b1; o_bch = 8'($urandom); b_q.push_back(o_bch);
      end
      o_awready = ($urandom_range(0, 3) != 0);
      o_wready  = ($urandom_range(0, 3) != 0);
      i_bready  = ($urandom_range(0, 3) != 0);
    end
    i_awvalid = 1'b0; i_wvalid = 1'b0; o_bvalid = 1'b0;
    chk("random_all_b", slv_b, N);
    chk("random_aw_q_empty", aw_q.size(), 0);
    chk("random_w_q_empty", w_q.size(), 0);
    chk("random_b_q_empty", b_q.size(), 0);
    do_reset();

    // B-wait watchdog: one write, no B
    do_aw(8'h71);
    do_w(8'h72, 1'b1);
    for (int c = 2; c <= 20; c++) begin
      to_drv();
      if (c == 14) chk("timeout_not_yet", err_timeout, 1'b0);
      if (c == 20) chk("timeout_fired", err_timeout, TO_EXP);
    end
    do_b(8'h73);
    to_neg();
    chk("timeout_sticky", err_timeout, TO_EXP);
    to_drv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
